// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_wb_arbiter_pkg
//   Shared constants for the register-file writeback arbiter:
//     ADDR_W / DATA_W : default register index and data widths
//     REG_ZERO        : index of the hard-wired $zero register
//     REQ_ALU/REQ_MEM : requester index encoding (bit position in valid/grant)
package regfile_wb_arbiter_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int REQ_ALU = 0;
  localparam int REQ_MEM = 1;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2
//   Two-way round-robin grant logic with its priority pointer.
//   Ports:
//     clk, reset : clock and synchronous active-high reset
//     valid[1:0] : request lines (bit REQ_ALU, bit REQ_MEM)
//     hold       : freeze; no grant and no pointer movement while high
//     grant[1:0] : one-hot (or zero) grant, combinational
//     conflict   : both requesters valid in a non-held cycle
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid,
  input  logic       hold,
  output logic [1:0] grant,
  output logic       conflict
);
  import regfile_wb_arbiter_pkg::*;

  // prio_q names the requester that wins the next conflict (0 = ALU).
  logic prio_q, prio_d;

  always_comb begin
    grant    = 2'b00;
    conflict = valid[REQ_ALU] && valid[REQ_MEM] && !hold;
    prio_d   = prio_q;
    if (!reset && !hold) begin
      if (conflict) begin
        // A granted requester is always valid, so a conflict always
        // accepts; hand priority to the loser.
        grant[prio_q] = 1'b1;
        prio_d        = ~prio_q;
      end else begin
        grant = valid;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) prio_q <= 1'b0;
    else       prio_q <= prio_d;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the single register-file write port between the ALU writeback
//   (requester 0) and the MEM/load writeback (requester 1). Round-robin,
//   one accept per cycle, write command registered one cycle after accept.
//   Writes to $zero complete the handshake but never raise rf_write.
//   Ports:
//     clk, reset                   : clock, synchronous active-high reset
//     hold                         : pipeline freeze, blocks all grants
//     reqN_valid/reqN_reg/reqN_data: writeback requests
//     reqN_ready                   : combinational accept
//     rf_write/_reg/_data          : registered register-file write command
//     pend_valid                   : copy of rf_write
//     conflict_count               : saturating count of dual-request cycles
//   Optional (macro RFWB_FORWARD_EN): rd_reg1/2, rf_rd_data1/2 inputs and
//   fwd_data1/2 outputs that bypass the in-flight write to readers.
module regfile_wb_arbiter #(
  parameter int DATA_W = regfile_wb_arbiter_pkg::DATA_W,
  parameter int ADDR_W = regfile_wb_arbiter_pkg::ADDR_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_reg,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_reg,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              rf_write,
  output logic [ADDR_W-1:0] rf_write_reg,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              pend_valid,
  output logic [CNT_W-1:0]  conflict_count
`ifdef RFWB_FORWARD_EN
  ,
  input  logic [ADDR_W-1:0] rd_reg1,
  input  logic [ADDR_W-1:0] rd_reg2,
  input  logic [DATA_W-1:0] rf_rd_data1,
  input  logic [DATA_W-1:0] rf_rd_data2,
  output logic [DATA_W-1:0] fwd_data1,
  output logic [DATA_W-1:0] fwd_data2
`endif
);
  import regfile_wb_arbiter_pkg::*;

  logic [1:0]        grant;
  logic              conflict;
  logic              accept;
  logic [ADDR_W-1:0] acc_reg;
  logic [DATA_W-1:0] acc_data;

  logic              rf_write_q, rf_write_d;
  logic [ADDR_W-1:0] rf_write_reg_q, rf_write_reg_d;
  logic [DATA_W-1:0] rf_write_data_q, rf_write_data_d;
  logic [CNT_W-1:0]  count_q, count_d;

  rr_arbiter2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .valid    ({req1_valid, req0_valid}),
    .hold     (hold),
    .grant    (grant),
    .conflict (conflict)
  );

  assign req0_ready = grant[REQ_ALU];
  assign req1_ready = grant[REQ_MEM];

  always_comb begin
    accept          = |grant;
    acc_reg         = grant[REQ_MEM] ? req1_reg  : req0_reg;
    acc_data        = grant[REQ_MEM] ? req1_data : req0_data;
    rf_write_d      = accept && (acc_reg != ADDR_W'(REG_ZERO));
    rf_write_reg_d  = accept ? acc_reg  : rf_write_reg_q;
    rf_write_data_d = accept ? acc_data : rf_write_data_q;
    count_d         = count_q;
    if (conflict && (count_q != {CNT_W{1'b1}}))
      count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_write_q      <= 1'b0;
      rf_write_reg_q  <= '0;
      rf_write_data_q <= '0;
      count_q         <= '0;
    end else begin
      rf_write_q      <= rf_write_d;
      rf_write_reg_q  <= rf_write_reg_d;
      rf_write_data_q <= rf_write_data_d;
      count_q         <= count_d;
    end
  end

  assign rf_write       = rf_write_q;
  assign rf_write_reg   = rf_write_reg_q;
  assign rf_write_data  = rf_write_data_q;
  assign pend_valid     = rf_write_q;
  assign conflict_count = count_q;

`ifdef RFWB_FORWARD_EN
  // The register file reads combinationally, so a read in the same cycle as
  // the strobe would return stale data; bypass the in-flight write.
  always_comb begin
    fwd_data1 = rf_rd_data1;
    fwd_data2 = rf_rd_data2;
    if (rf_write_q && (rf_write_reg_q == rd_reg1) && (rd_reg1 != ADDR_W'(REG_ZERO)))
      fwd_data1 = rf_write_data_q;
    if (rf_write_q && (rf_write_reg_q == rd_reg2) && (rd_reg2 != ADDR_W'(REG_ZERO)))
      fwd_data2 = rf_write_data_q;
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        hold;
  logic        req0_valid, req1_valid;
  logic [4:0]  req0_reg, req1_reg;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        rf_write;
  logic [4:0]  rf_write_reg;
  logic [31:0] rf_write_data;
  logic        pend_valid;
  logic [15:0] conflict_count;
`ifdef RFWB_FORWARD_EN
  logic [4:0]  rd_reg1, rd_reg2;
  logic [31:0] rf_rd_data1, rf_rd_data2;
  logic [31:0] fwd_data1, fwd_data2;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .hold           (hold),
    .req0_valid     (req0_valid),
    .req0_reg       (req0_reg),
    .req0_data      (req0_data),
    .req0_ready     (req0_ready),
    .req1_valid     (req1_valid),
    .req1_reg       (req1_reg),
    .req1_data      (req1_data),
    .req1_ready     (req1_ready),
    .rf_write       (rf_write),
    .rf_write_reg   (rf_write_reg),
    .rf_write_data  (rf_write_data),
    .pend_valid     (pend_valid),
    .conflict_count (conflict_count)
`ifdef RFWB_FORWARD_EN
    ,
    .rd_reg1        (rd_reg1),
    .rd_reg2        (rd_reg2),
    .rf_rd_data1    (rf_rd_data1),
    .rf_rd_data2    (rf_rd_data2),
    .fwd_data1      (fwd_data1),
    .fwd_data2      (fwd_data2)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hand-computed grant order for four conflict cycles starting at prio=0.
  logic [4:0]  exp_reg  [4] = '{5'd3, 5'd4, 5'd3, 5'd4};
  logic [31:0] exp_data [4] = '{32'h11, 32'h22, 32'h111, 32'h122};

  initial begin
    reset = 1'b1; hold = 1'b0;
    req0_valid = 1'b0; req0_reg = '0; req0_data = '0;
    req1_valid = 1'b0; req1_reg = '0; req1_data = '0;
`ifdef RFWB_FORWARD_EN
    rd_reg1 = '0; rd_reg2 = '0; rf_rd_data1 = '0; rf_rd_data2 = '0;
`endif

    // Reset: readies stay low even with both requests raised.
    step();
    req0_valid = 1'b1; req0_reg = 5'd9; req0_data = 32'h99;
    req1_valid = 1'b1; req1_reg = 5'd8; req1_data = 32'h88;
    #1;
    chk("rst_ready0", 32'(req0_ready), 32'd0);
    chk("rst_ready1", 32'(req1_ready), 32'd0);
    step();
    chk("rst_rf_write", 32'(rf_write), 32'd0);
    chk("rst_pend", 32'(pend_valid), 32'd0);
    chk("rst_count", 32'(conflict_count), 32'd0);
    chk("rst_wreg", 32'(rf_write_reg), 32'd0);
    chk("rst_wdata", rf_write_data, 32'd0);

    // Idle after reset.
    req0_valid = 1'b0; req1_valid = 1'b0; reset = 1'b0;
    step();
    chk("idle_rf_write", 32'(rf_write), 32'd0);

    // Single ALU request.
    req0_valid = 1'b1; req0_reg = 5'd5; req0_data = 32'hDEADBEEF;
    #1;
    chk("alu_ready0", 32'(req0_ready), 32'd1);
    chk("alu_ready1", 32'(req1_ready), 32'd0);
    step();
    req0_valid = 1'b0;
    chk("alu_rf_write", 32'(rf_write), 32'd1);
    chk("alu_pend", 32'(pend_valid), 32'd1);
    chk("alu_wreg", 32'(rf_write_reg), 32'd5);
    chk("alu_wdata", rf_write_data, 32'hDEADBEEF);
    step();
    chk("alu_strobe_drop", 32'(rf_write), 32'd0);
    chk("alu_wreg_held", 32'(rf_write_reg), 32'd5);

    // Dual requests from a fresh reset: grants alternate ALU, MEM, ALU, MEM.
    reset = 1'b1;
    step();
    reset = 1'b0;
    req0_valid = 1'b1; req0_reg = 5'd3; req0_data = 32'h11;
    req1_valid = 1'b1; req1_reg = 5'd4; req1_data = 32'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr%0d_ready0", i), 32'(req0_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("rr%0d_ready1", i), 32'(req1_ready), (i % 2 == 1) ? 32'd1 : 32'd0);
      step();
      chk($sformatf("rr%0d_wreg", i), 32'(rf_write_reg), 32'(exp_reg[i]));
      chk($sformatf("rr%0d_wdata", i), rf_write_data, exp_data[i]);
      chk($sformatf("rr%0d_rf_write", i), 32'(rf_write), 32'd1);
      // The accepted requester presents its next writeback.
      if (i % 2 == 0) req0_data = req0_data + 32'h100;
      else            req1_data = req1_data + 32'h100;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("rr_count", 32'(conflict_count), 32'd4);

    // MEM write to $zero: handshake completes, no strobe.
    req1_valid = 1'b1; req1_reg = 5'd0; req1_data = 32'hFFFFFFFF;
    #1;
    chk("zero_ready1", 32'(req1_ready), 32'd1);
    step();
    req1_valid = 1'b0;
    chk("zero_rf_write", 32'(rf_write), 32'd0);
    chk("zero_wreg", 32'(rf_write_reg), 32'd0);
    chk("zero_wdata", rf_write_data, 32'hFFFFFFFF);
    chk("zero_count", 32'(conflict_count), 32'd4);

    // One conflict cycle so MEM holds priority, then freeze for 3 cycles.
    req0_valid = 1'b1; req0_reg = 5'd10; req0_data = 32'hA0;
    req1_valid = 1'b1; req1_reg = 5'd11; req1_data = 32'hB0;
    #1;
    chk("pre_hold_ready0", 32'(req0_ready), 32'd1);
    step();
    req0_data = 32'hA1;
    hold = 1'b1;
    chk("pre_hold_count", 32'(conflict_count), 32'd5);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("hold%0d_ready0", i), 32'(req0_ready), 32'd0);
      chk($sformatf("hold%0d_ready1", i), 32'(req1_ready), 32'd0);
      step();
      chk($sformatf("hold%0d_rf_write", i), 32'(rf_write), 32'd0);
      chk($sformatf("hold%0d_count", i), 32'(conflict_count), 32'd5);
    end
    hold = 1'b0;
    #1;
    chk("rel_ready1", 32'(req1_ready), 32'd1);
    chk("rel_ready0", 32'(req0_ready), 32'd0);
    step();
    chk("rel_wreg", 32'(rf_write_reg), 32'd11);
    chk("rel_wdata", rf_write_data, 32'hB0);
    chk("rel_count", 32'(conflict_count), 32'd6);
    req1_valid = 1'b0;
    #1;
    chk("rel2_ready0", 32'(req0_ready), 32'd1);
    step();
    req0_valid = 1'b0;
    chk("rel2_wreg", 32'(rf_write_reg), 32'd10);
    chk("rel2_wdata", rf_write_data, 32'hA1);

`ifdef RFWB_FORWARD_EN
    // Forwarding of the in-flight write.
    req0_valid = 1'b1; req0_reg = 5'd7; req0_data = 32'h1234;
    step();
    req0_valid = 1'b0;
    rd_reg1 = 5'd7; rf_rd_data1 = 32'h0;
    rd_reg2 = 5'd6; rf_rd_data2 = 32'h5555;
    #1;
    chk("fwd1_hit", fwd_data1, 32'h1234);
    chk("fwd2_miss", fwd_data2, 32'h5555);
    rd_reg1 = 5'd0; rf_rd_data1 = 32'hAAAA;
    #1;
    chk("fwd1_zero", fwd_data1, 32'hAAAA);
    step();
    rd_reg1 = 5'd7; rf_rd_data1 = 32'h7777;
    #1;
    chk("fwd1_no_strobe", fwd_data1, 32'h7777);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single write port of the 32x32 register file between two writeback requesters: req 0 = ALU writeback, req 1 = MEM/load writeback.
- Each requester uses a valid/ready handshake.
- Round-robin arbitration; one write per cycle.
- The write command is registered, so the register file sees a clean write strobe one cycle after acceptance.
- Sits between the execute/memory stages and the register file write inputs (write, writeReg, writeData).

Parameters:
- DATA_W, 32, data width of a writeback.
- ADDR_W, 5, register index width.
- CNT_W, 16, width of the saturating conflict counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- hold  input  1  pipeline freeze; no grants while high.
- req0_valid  input  1  ALU writeback request.
- req0_reg  input  ADDR_W  ALU destination register.
- req0_data  input  DATA_W  ALU result.
- req0_ready  output  1  ALU request accepted this cycle (combinational).
- req1_valid  input  1  MEM writeback request.
- req1_reg  input  ADDR_W  MEM destination register.
- req1_data  input  DATA_W  load data.
- req1_ready  output  1  MEM request accepted this cycle (combinational).
- rf_write  output  1  register-file write strobe (registered).
- rf_write_reg  output  ADDR_W  register-file write index (registered).
- rf_write_data  output  DATA_W  register-file write data (registered).
- pend_valid  output  1  same as rf_write; a write is in flight.
- conflict_count  output  CNT_W  cycles in which both requesters were valid.

Behaviour:
- Reset (reset high at a rising edge):
  - rf_write=0, rf_write_reg=0, rf_write_data=0, pend_valid=0, conflict_count=0.
  - Priority pointer prio=0 (ALU favoured).
  - Reset overrides everything in the same cycle, including an in-flight handshake.
  - During reset both readies are 0.
- Grant logic (combinational):
  - hold=1 → req0_ready=req1_ready=0.
  - Else, only one valid → that requester's ready=1.
  - Else, both valid → ready goes to the requester selected by prio; the other's ready=0.
  - Requests are accepted only when valid&&ready.
- Pointer update:
  - On an accept during a conflict cycle, prio moves to the non-granted requester.
  - On a non-conflict accept, prio is unchanged.
  - prio never changes while hold=1.
- Output stage: on each clk edge with no reset:
  - rf_write <= accepted && (accepted_reg != 0).
  - rf_write_reg <= accepted_reg and rf_write_data <= accepted_data when accepted; otherwise both hold their previous value.
  - Latency from accept to rf_write = 1 cycle.
  - rf_write is never high for two cycles unless there are two consecutive accepts.
- Writes to register 0:
  - Handshake completes (ready=1) but rf_write stays 0, so $zero is never written.
  - rf_write_reg/rf_write_data still update.
- Requester obligations: a requester must hold valid, reg and data stable until ready; dropping valid early is a protocol error (not checked).
- conflict_count:
  - Increments when req0_valid&&req1_valid&&!hold.
  - Saturates at all-ones; no wrap.
- hold asserted mid-conflict: both requesters stall, prio is kept, and the stalled requester still wins first after hold falls.
- Throughput: one write per cycle sustained. Under continuous dual requests, grants alternate 0,1,0,1...

Optional Feature:
- Macro RFWB_FORWARD_EN.
- When defined, adds:
  - Inputs rd_reg1, rd_reg2 (ADDR_W) and rf_rd_data1, rf_rd_data2 (DATA_W).
  - Outputs fwd_data1, fwd_data2.
  - Rule: fwd_dataN = rf_write_data when rf_write && rf_write_reg==rd_regN && rd_regN!=0; otherwise rf_rd_dataN.
  - This covers the write-then-read ordering hazard of the combinational register file.
- When undefined: none of these ports exist; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - Constants ADDR_W=5 and DATA_W=32.
  - Constant REG_ZERO=5'd0.
  - Requester index encoding REQ_ALU=0, REQ_MEM=1.
- One sub-module: rr_arbiter2, the 2-way round-robin grant logic plus the prio flop. Its inputs are valid[1:0] and hold; its outputs are grant[1:0] and conflict.
- Output register and counter stay in the top module.

Test Plan:
- Reset then idle → rf_write=0, conflict_count=0, readies=0 during reset.
- req0 only, reg=5, data=0xDEADBEEF → req0_ready=1 same cycle; next cycle rf_write=1, rf_write_reg=5, rf_write_data=0xDEADBEEF.
- Both valid for 4 cycles (ALU reg 3/0x11, MEM reg 4/0x22, new data each accept), starting from reset → grant order ALU, MEM, ALU, MEM; conflict_count=4.
- req1 writes reg 0 with 0xFFFFFFFF → req1_ready=1; rf_write stays 0 next cycle.
- Both valid with hold=1 for 3 cycles, then hold=0 → no readies and no rf_write during hold; conflict_count unchanged; prio winner granted first after release.
- With RFWB_FORWARD_EN: ALU write reg 7 = 0x1234, rd_reg1=7 during the rf_write cycle with rf_rd_data1=0 → fwd_data1=0x1234. Repeat with rd_reg1=0 → fwd_data1=rf_rd_data1.
